// File: rtl/acc_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// acc_uart_tx_pkg
// Shared definitions for the accumulator UART path.
// Contents:
//   state_t               transmitter state encoding (IDLE/START/DATA/STOP)
//   UART_FRAME_BITS       bits per 8N1 character (start + 8 data + stop)
//   DEFAULT_CLKS_PER_BIT  default bit time in clock cycles
// ---------------------------------------------------------------------------
package acc_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int UART_FRAME_BITS      = 10;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/acc_uart_tx_baud_tick_gen.sv
// ---------------------------------------------------------------------------
// baud_tick_gen
// Bit-time counter that pulses tick once every CLKS_PER_BIT cycles.
// Shared by the accumulator UART transmitter and its matching receiver.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   clear  in   hold the counter at zero (phase restart)
//   tick   out  high in the last cycle of each bit time
// ---------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign tick = (count == LAST);

    // Counts 0..CLKS_PER_BIT-1 and wraps; clear keeps the phase at zero so
    // the first bit after a restart gets its full duration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/acc_uart_tx.sv
// ---------------------------------------------------------------------------
// acc_uart_tx
// Captures the 16-bit accumulator on a Send strobe and transmits it as two
// UART 8N1 characters, low byte first, each byte LSB first, with no idle gap
// between the two characters.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   Dato   in   accumulator value to transmit
//   Send   in   one-cycle request, accepted only while idle
//   Tx     out  serial line, idles high
//   Busy   out  high while a two-byte frame is in progress
//   Done   out  one-cycle pulse when the final stop bit completes
// ---------------------------------------------------------------------------
module acc_uart_tx
    import acc_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] Dato,
    input  logic        Send,
    output logic        Tx,
    output logic        Busy,
    output logic        Done
);

    state_t      state;
    logic [15:0] shreg;
    logic        byte_sel;
    logic [2:0]  bit_idx;
    logic        tick;
    logic        clear_cnt;

    // The bit timer is held in reset while idle, so a frame always starts
    // on a fresh bit boundary.
    assign clear_cnt = (state == IDLE);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear_cnt),
        .tick (tick)
    );

    // The whole 16-bit word lives in one shift register: after the eight
    // low-byte shifts the high byte has moved down into bits [7:0], so the
    // second character needs no reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            byte_sel <= 1'b0;
            bit_idx  <= '0;
            Tx       <= 1'b1;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Send) begin
                        shreg    <= Dato;
                        byte_sel <= 1'b0;
                        bit_idx  <= '0;
                        state    <= START;
                        Tx       <= 1'b0;
                        Busy     <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        Tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[15:1]};
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            Tx      <= 1'b1;
                            bit_idx <= '0;
                        end else begin
                            Tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[15:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (!byte_sel) begin
                            byte_sel <= 1'b1;
                            state    <= START;
                            Tx       <= 1'b0;
                        end else begin
                            byte_sel <= 1'b0;
                            state    <= IDLE;
                            Busy     <= 1'b0;
                            Done     <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    Tx    <= 1'b1;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_acc_uart_tx
// Self-checking bench for acc_uart_tx with CLKS_PER_BIT = 4. The expected
// line waveform is derived from the 8N1 framing rules of the accumulator
// word (start, 8 data LSB first, stop; low byte then high byte).
// ---------------------------------------------------------------------------
module tb_acc_uart_tx;
    import acc_uart_tx_pkg::*;

    localparam int CPB        = 4;
    localparam int FRAME_CYC  = 2 * UART_FRAME_BITS * CPB;

    logic        clk;
    logic        rst_n;
    logic [15:0] Dato;
    logic        Send;
    logic        Tx;
    logic        Busy;
    logic        Done;

    int total;
    int bad;

    acc_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .Dato (Dato),
        .Send (Send),
        .Tx   (Tx),
        .Busy (Busy),
        .Done (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line level during bit slot idx (0..19) of a two-character frame.
    function automatic logic frame_bit(input logic [15:0] v, input int idx);
        int pos;
        int byte_no;
        pos     = idx % UART_FRAME_BITS;
        byte_no = idx / UART_FRAME_BITS;
        if (pos == 0) return 1'b0;
        if (pos == UART_FRAME_BITS - 1) return 1'b1;
        return v[byte_no * 8 + pos - 1];
    endfunction

    // Requests a frame; returns at the first sample point after the
    // capturing edge.
    task automatic drive_send(input logic [15:0] v);
        @(negedge clk);
        Dato = v;
        Send = 1'b1;
        @(negedge clk);
        Send = 1'b0;
    endtask

    // Line must stay idle for n sample points.
    task automatic idle_check(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            total++;
            if ({Tx, Busy, Done} !== 3'b100) begin
                bad++;
                $display("[TB] FAIL %s cycle %0d: tx/busy/done got %b expected 100",
                         name, k, {Tx, Busy, Done});
            end
            @(negedge clk);
        end
    endtask

    // Checks every cycle of a frame carrying v, starting at the first
    // sample point after the capturing edge, and then the Done cycle.
    // extra_k: cycle at which to issue a Send that must be ignored (-1 none).
    // scramble: change Dato every cycle. chain: Send again in the Done cycle.
    task automatic check_frame(input string name, input logic [15:0] v,
                               input int extra_k, input logic [15:0] extra_v,
                               input bit scramble, input bit chain,
                               input logic [15:0] chain_v);
        logic [2:0] exp;
        for (int k = 0; k < FRAME_CYC; k++) begin
            exp = {frame_bit(v, k / CPB), 1'b1, 1'b0};
            total++;
            if ({Tx, Busy, Done} !== exp) begin
                bad++;
                $display("[TB] FAIL %s cycle %0d: tx/busy/done got %b expected %b",
                         name, k, {Tx, Busy, Done}, exp);
            end
            Send = 1'b0;
            if (k == extra_k) begin
                Send = 1'b1;
                Dato = extra_v;
            end else if (scramble) begin
                Dato = 16'($urandom);
            end
            @(negedge clk);
        end
        total++;
        if ({Tx, Busy, Done} !== 3'b101) begin
            bad++;
            $display("[TB] FAIL %s done: tx/busy/done got %b expected 101",
                     name, {Tx, Busy, Done});
        end
        if (chain) begin
            Dato = chain_v;
            Send = 1'b1;
            @(negedge clk);
            Send = 1'b0;
        end else begin
            Send = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({Tx, Busy, Done} !== 3'b100) begin
                bad++;
                $display("[TB] FAIL reset cycle %0d: tx/busy/done got %b expected 100",
                         k, {Tx, Busy, Done});
            end
        end
        rst_n = 1'b1;
        idle_check("post_reset_idle", 50);
    endtask

    task automatic test_basic();
        drive_send(16'hA55A);
        check_frame("basic_a55a", 16'hA55A, -1, 16'h0, 1'b0, 1'b0, 16'h0);
        idle_check("basic_after", 4);
    endtask

    task automatic test_ignore_busy();
        drive_send(16'h00FF);
        check_frame("ignore_busy", 16'h00FF, 10, 16'h1234, 1'b0, 1'b0, 16'h0);
        idle_check("ignore_after", 8);
    endtask

    task automatic test_back_to_back();
        logic [15:0] first;
        first = 16'($urandom);
        drive_send(first);
        check_frame("b2b_first", first, -1, 16'h0, 1'b0, 1'b1, 16'hFFFF);
        check_frame("b2b_ffff", 16'hFFFF, -1, 16'h0, 1'b0, 1'b0, 16'h0);
        idle_check("b2b_after", 4);
    endtask

    task automatic test_reset_midframe();
        logic [15:0] v;
        v = 16'($urandom);
        drive_send(v);
        // Cycle 50 lies inside the high-byte data bits.
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({Tx, Busy, Done} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL reset_async: tx/busy/done got %b expected 100",
                     {Tx, Busy, Done});
        end
        @(negedge clk);
        idle_check("reset_held", 4);
        rst_n = 1'b1;
        idle_check("reset_release", 10);
        drive_send(16'h0001);
        check_frame("after_reset_0001", 16'h0001, -1, 16'h0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_dato_scramble();
        drive_send(16'h8001);
        check_frame("scramble_8001", 16'h8001, -1, 16'h0, 1'b1, 1'b0, 16'h0);
        idle_check("scramble_after", 4);
    endtask

    task automatic test_random();
        logic [15:0] cur;
        logic [15:0] nxt;
        bit          chain;
        bit          scr;
        cur = 16'($urandom);
        drive_send(cur);
        for (int i = 0; i < 6; i++) begin
            nxt   = 16'($urandom);
            chain = (i < 5) && ($urandom_range(0, 1) == 1);
            scr   = ($urandom_range(0, 1) == 1);
            check_frame("random", cur, -1, 16'h0, scr, chain, nxt);
            if (!chain && i < 5) begin
                idle_check("random_gap", $urandom_range(1, 5));
                drive_send(nxt);
            end
            cur = nxt;
        end
        idle_check("random_after", 4);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        Send  = 1'b0;
        Dato  = 16'h0;
        test_reset();
        test_basic();
        test_ignore_busy();
        test_back_to_back();
        test_reset_midframe();
        test_dato_scramble();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
